// File: rtl/reg_file_arbiter.sv
// Round-robin arbiter sharing one single-port register file between the UART
// command decoder (port 0) and the processor core (port 1), one transaction at a time.
module reg_file_arbiter #(
    parameter int DATA_WIDTH          = 8,
    parameter int REGISTER_FILE_DEPTH = 16,
    parameter int TIMEOUT_CYCLES      = 15,
    localparam int AW = $clog2(REGISTER_FILE_DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [AW-1:0]         addr0,
    input  logic [AW-1:0]         addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  ack0,
    output logic                  ack1,
    output logic                  err0,
    output logic                  err1,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic [AW-1:0]         rf_address,
    output logic                  rf_write_en,
    output logic [DATA_WIDTH-1:0] rf_write_data,
    output logic                  rf_read_en,
    input  logic                  rf_read_data_valid,
    input  logic [DATA_WIDTH-1:0] rf_read_data,
    output logic                  busy,
    output logic                  grant_id
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ISSUE   = 2'd1;
    localparam logic [1:0] WAIT_RD = 2'd2;
    localparam logic [1:0] RESP    = 2'd3;

    logic [1:0]    state;
    logic          last_grant;
    logic          we_latched;
    logic [CW-1:0] cnt;
    logic          pick1;

    // On a tie the port that did not own the previous transaction wins.
    assign pick1 = req1 && (!req0 || !last_grant);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            last_grant    <= 1'b1;
            we_latched    <= 1'b0;
            cnt           <= '0;
            ack0          <= 1'b0;
            ack1          <= 1'b0;
            err0          <= 1'b0;
            err1          <= 1'b0;
            rdata0        <= '0;
            rdata1        <= '0;
            rf_address    <= '0;
            rf_write_en   <= 1'b0;
            rf_write_data <= '0;
            rf_read_en    <= 1'b0;
            busy          <= 1'b0;
            grant_id      <= 1'b0;
        end else begin
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            err0        <= 1'b0;
            err1        <= 1'b0;
            rf_write_en <= 1'b0;
            rf_read_en  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        grant_id      <= pick1;
                        we_latched    <= pick1 ? we1 : we0;
                        rf_address    <= pick1 ? addr1 : addr0;
                        rf_write_data <= pick1 ? wdata1 : wdata0;
                        // Enables are registered so they are high during the ISSUE cycle.
                        rf_write_en   <= pick1 ? we1 : we0;
                        rf_read_en    <= pick1 ? !we1 : !we0;
                        busy          <= 1'b1;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (we_latched) begin
                        ack0  <= !grant_id;
                        ack1  <= grant_id;
                        state <= RESP;
                    end else begin
                        cnt   <= '0;
                        state <= WAIT_RD;
                    end
                end
                WAIT_RD: begin
                    if (rf_read_data_valid) begin
                        if (grant_id) begin
                            rdata1 <= rf_read_data;
                            ack1   <= 1'b1;
                        end else begin
                            rdata0 <= rf_read_data;
                            ack0   <= 1'b1;
                        end
                        state <= RESP;
                    end else if (cnt == CNT_MAX) begin
                        if (grant_id) begin
                            rdata1 <= '0;
                            ack1   <= 1'b1;
                            err1   <= 1'b1;
                        end else begin
                            rdata0 <= '0;
                            ack0   <= 1'b1;
                            err0   <= 1'b1;
                        end
                        state <= RESP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RESP: begin
                    last_grant <= grant_id;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_file_arbiter.sv
// Directed bench for reg_file_arbiter with a behavioural registered register file
// that can be stubbed to never return read-data-valid.
module tb_reg_file_arbiter;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int TO = 15;

    logic          clk;
    logic          reset_n;
    logic          req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          ack0, ack1, err0, err1;
    logic [DW-1:0] rdata0, rdata1;
    logic [AW-1:0] rf_address;
    logic          rf_write_en, rf_read_en;
    logic [DW-1:0] rf_write_data;
    logic          rf_read_data_valid = 1'b0;
    logic [DW-1:0] rf_read_data = '0;
    logic          busy, grant_id;
    logic          rf_stub = 1'b0;

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] mem [16] = '{8'h00, 8'h10, 8'h01, 8'h08, 8'h44, 8'h55, 8'h66, 8'h77,
                                8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};

    reg_file_arbiter #(
        .DATA_WIDTH(DW),
        .REGISTER_FILE_DEPTH(16),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .req0(req0),
        .req1(req1),
        .we0(we0),
        .we1(we1),
        .addr0(addr0),
        .addr1(addr1),
        .wdata0(wdata0),
        .wdata1(wdata1),
        .ack0(ack0),
        .ack1(ack1),
        .err0(err0),
        .err1(err1),
        .rdata0(rdata0),
        .rdata1(rdata1),
        .rf_address(rf_address),
        .rf_write_en(rf_write_en),
        .rf_write_data(rf_write_data),
        .rf_read_en(rf_read_en),
        .rf_read_data_valid(rf_read_data_valid),
        .rf_read_data(rf_read_data),
        .busy(busy),
        .grant_id(grant_id)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Registered register file: read data and valid appear the cycle after read_en.
    always @(posedge clk) begin
        rf_read_data_valid <= 1'b0;
        if (rf_write_en) mem[rf_address] <= rf_write_data;
        if (rf_read_en && !rf_stub) begin
            rf_read_data       <= mem[rf_address];
            rf_read_data_valid <= 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        tick();
        tick();
        checks++; if ({ack0, ack1, err0, err1, busy, grant_id, rf_write_en, rf_read_en} !== 8'h00) begin
            failures++; $display("FAIL reset_ctrl: got %b want 00000000", {ack0, ack1, err0, err1, busy, grant_id, rf_write_en, rf_read_en});
        end
        checks++; if ({rdata0, rdata1, rf_address, rf_write_data} !== 28'h0) begin
            failures++; $display("FAIL reset_data: got %h want 0", {rdata0, rdata1, rf_address, rf_write_data});
        end
        #2 reset_n = 1'b1;
        tick();
        checks++; if ({busy, ack0, ack1, rf_read_en, rf_write_en} !== 5'b0) begin
            failures++; $display("FAIL reset_idle: got %b want 00000", {busy, ack0, ack1, rf_read_en, rf_write_en});
        end
    endtask

    task automatic test_read();
        logic [AW-1:0] a [2];
        logic [DW-1:0] e [2];
        a[0] = 4'd2; e[0] = 8'h01;
        a[1] = 4'd3; e[1] = 8'h08;
        for (int i = 0; i < 2; i++) begin
            addr0 = a[i]; we0 = 1'b0; req0 = 1'b1;
            tick();
            checks++; if ({rf_read_en, rf_write_en, rf_address} !== {1'b1, 1'b0, a[i]}) begin
                failures++; $display("FAIL read%0d_issue: got %b want %b", i, {rf_read_en, rf_write_en, rf_address}, {1'b1, 1'b0, a[i]});
            end
            checks++; if ({busy, grant_id} !== 2'b10) begin
                failures++; $display("FAIL read%0d_busy_gid: got %b want 10", i, {busy, grant_id});
            end
            tick();
            checks++; if ({ack0, rf_read_en} !== 2'b00) begin
                failures++; $display("FAIL read%0d_wait: got %b want 00", i, {ack0, rf_read_en});
            end
            tick();
            checks++; if ({ack0, err0, ack1, rdata0} !== {3'b100, e[i]}) begin
                failures++; $display("FAIL read%0d_ack: got %h want %h", i, {ack0, err0, ack1, rdata0}, {3'b100, e[i]});
            end
            req0 = 1'b0;
            tick();
            checks++; if ({ack0, busy} !== 2'b00) begin
                failures++; $display("FAIL read%0d_done: got %b want 00", i, {ack0, busy});
            end
        end
    endtask

    task automatic test_write();
        req1 = 1'b1; we1 = 1'b1; addr1 = 4'd5; wdata1 = 8'hA5;
        tick();
        checks++; if ({rf_write_en, rf_read_en, rf_address, rf_write_data} !== {1'b1, 1'b0, 4'd5, 8'hA5}) begin
            failures++; $display("FAIL write_issue: got %h want %h", {rf_write_en, rf_read_en, rf_address, rf_write_data}, {1'b1, 1'b0, 4'd5, 8'hA5});
        end
        checks++; if (grant_id !== 1'b1) begin
            failures++; $display("FAIL write_gid: got %b want 1", grant_id);
        end
        tick();
        checks++; if ({ack1, err1, ack0, rf_write_en} !== 4'b1000) begin
            failures++; $display("FAIL write_ack: got %b want 1000", {ack1, err1, ack0, rf_write_en});
        end
        req1 = 1'b0;
        tick();
        checks++; if ({ack1, busy, rdata1} !== 10'h0) begin
            failures++; $display("FAIL write_done: got %h want 0", {ack1, busy, rdata1});
        end
        // Port 1 reads addr 3 so its rdata holds a nonzero value for later tests.
        req1 = 1'b1; we1 = 1'b0; addr1 = 4'd3;
        tick(); tick(); tick();
        checks++; if ({ack1, err1, rdata1} !== {2'b10, 8'h08}) begin
            failures++; $display("FAIL read1_ack: got %h want %h", {ack1, err1, rdata1}, {2'b10, 8'h08});
        end
        req1 = 1'b0;
        tick();
        req0 = 1'b1; we0 = 1'b0; addr0 = 4'd5;
        tick(); tick(); tick();
        checks++; if ({ack0, err0, rdata0} !== {2'b10, 8'hA5}) begin
            failures++; $display("FAIL readback_ack: got %h want %h", {ack0, err0, rdata0}, {2'b10, 8'hA5});
        end
        checks++; if ({ack1, rdata1} !== {1'b0, 8'h08}) begin
            failures++; $display("FAIL readback_other: got %h want %h", {ack1, rdata1}, {1'b0, 8'h08});
        end
        req0 = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        int n;
        rf_stub = 1'b1;
        req1 = 1'b1; we1 = 1'b0; addr1 = 4'd7;
        tick();
        checks++; if ({rf_read_en, grant_id} !== 2'b11) begin
            failures++; $display("FAIL timeout_issue: got %b want 11", {rf_read_en, grant_id});
        end
        n = 0;
        while (n < 40) begin
            tick();
            n++;
            if (ack1) break;
        end
        checks++; if (n !== TO + 2) begin
            failures++; $display("FAIL timeout_latency: got %0d want %0d", n, TO + 2);
        end
        checks++; if ({ack1, err1, rdata1} !== {2'b11, 8'h00}) begin
            failures++; $display("FAIL timeout_resp: got %h want %h", {ack1, err1, rdata1}, {2'b11, 8'h00});
        end
        checks++; if ({ack0, err0, rdata0} !== {2'b00, 8'hA5}) begin
            failures++; $display("FAIL timeout_other: got %h want %h", {ack0, err0, rdata0}, {2'b00, 8'hA5});
        end
        req1 = 1'b0;
        tick();
        checks++; if ({busy, ack1, err1} !== 3'b000) begin
            failures++; $display("FAIL timeout_done: got %b want 000", {busy, ack1, err1});
        end
        rf_stub = 1'b0;
    endtask

    task automatic test_back_to_back();
        int k, cyc;
        logic g, both_en;
        logic [DW-1:0] exp1;
        req0 = 1'b1; we0 = 1'b0; addr0 = 4'd5;
        req1 = 1'b1; we1 = 1'b0; addr1 = 4'd3;
        k = 0; cyc = 0; both_en = 1'b0; exp1 = 8'h00;
        while (k < 6 && cyc < 200) begin
            tick();
            cyc++;
            if (rf_write_en && rf_read_en) both_en = 1'b1;
            if (ack0 || ack1) begin
                g = k[0];
                checks++; if (grant_id !== g) begin
                    failures++; $display("FAIL b2b_gid%0d: got %b want %b", k, grant_id, g);
                end
                checks++; if ({ack0, ack1} !== (g ? 2'b01 : 2'b10)) begin
                    failures++; $display("FAIL b2b_ack%0d: got %b want %b", k, {ack0, ack1}, (g ? 2'b01 : 2'b10));
                end
                if (g) exp1 = 8'h08;
                checks++; if ({rdata0, rdata1} !== {8'hA5, exp1}) begin
                    failures++; $display("FAIL b2b_rdata%0d: got %h want %h", k, {rdata0, rdata1}, {8'hA5, exp1});
                end
                k++;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        checks++; if (k !== 6 || cyc !== 23) begin
            failures++; $display("FAIL b2b_count: got acks=%0d cycles=%0d want acks=6 cycles=23", k, cyc);
        end
        checks++; if (both_en !== 1'b0) begin
            failures++; $display("FAIL b2b_both_en: got %b want 0", both_en);
        end
        tick();
    endtask

    task automatic test_abort();
        logic seen;
        rf_stub = 1'b1;
        req0 = 1'b1; we0 = 1'b0; addr0 = 4'd2;
        tick(); tick(); tick();
        #2 reset_n = 1'b0;
        #1;
        checks++; if ({ack0, ack1, err0, err1, busy, grant_id, rf_write_en, rf_read_en} !== 8'h00) begin
            failures++; $display("FAIL abort_ctrl: got %b want 00000000", {ack0, ack1, err0, err1, busy, grant_id, rf_write_en, rf_read_en});
        end
        checks++; if ({rdata0, rdata1, rf_address, rf_write_data} !== 28'h0) begin
            failures++; $display("FAIL abort_data: got %h want 0", {rdata0, rdata1, rf_address, rf_write_data});
        end
        req0 = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (ack0 || ack1 || busy) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin
            failures++; $display("FAIL abort_no_ack: got %b want 0", seen);
        end
        rf_stub = 1'b0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 4'd2;
        req1 = 1'b1; we1 = 1'b0; addr1 = 4'd3;
        tick();
        checks++; if ({busy, grant_id} !== 2'b10) begin
            failures++; $display("FAIL abort_tie_gid: got %b want 10", {busy, grant_id});
        end
        tick(); tick();
        checks++; if ({ack0, ack1, rdata0} !== {2'b10, 8'h01}) begin
            failures++; $display("FAIL abort_tie_ack: got %h want %h", {ack0, ack1, rdata0}, {2'b10, 8'h01});
        end
        req0 = 1'b0; req1 = 1'b0;
        tick();
    endtask

    task automatic test_drop();
        int pulses;
        req0 = 1'b1; we0 = 1'b0; addr0 = 4'd3;
        tick();
        req0 = 1'b0;
        tick(); tick();
        checks++; if ({ack0, err0, rdata0} !== {2'b10, 8'h08}) begin
            failures++; $display("FAIL drop_ack: got %h want %h", {ack0, err0, rdata0}, {2'b10, 8'h08});
        end
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (ack0 || busy) pulses++;
        end
        checks++; if (pulses !== 0) begin
            failures++; $display("FAIL drop_no_retrans: got %0d want 0", pulses);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_read();
        test_write();
        test_timeout();
        test_back_to_back();
        test_abort();
        test_drop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_file_arbiter.md
Name: reg_file_arbiter

Overview:
Shares the single-port register file between two requesters: port 0 is the UART command decoder and port 1 is the processor core. The block arbitrates round-robin and runs one transaction at a time. It never asserts the register file's write and read enables together, and it waits for the register file's registered read-data-valid before responding. It sits directly in front of register_file and drives all of that block's address, enable and data inputs.

Parameters:
DATA_WIDTH, 8, width of register data
REGISTER_FILE_DEPTH, 16, number of registers; AW = $clog2(REGISTER_FILE_DEPTH)
TIMEOUT_CYCLES, 15, maximum cycles spent in WAIT_RD before an error response (minimum 1)

Ports:
clk  input  1  clock; all logic is on the rising edge
reset_n  input  1  asynchronous active-low reset
req0, req1  input  1 each  transaction request; level-sensitive
we0, we1  input  1 each  1 = write, 0 = read; sampled at grant
addr0, addr1  input  AW each  register address; sampled at grant
wdata0, wdata1  input  DATA_WIDTH each  write data; sampled at grant
ack0, ack1  output  1 each  one-cycle completion pulse
err0, err1  output  1 each  valid with ack; 1 = read timeout
rdata0, rdata1  output  DATA_WIDTH each  read result; updated only on a read ack to that port, held otherwise
rf_address  output  AW  to register file address
rf_write_en  output  1  to register file write_en
rf_write_data  output  DATA_WIDTH  to register file write_data
rf_read_en  output  1  to register file read_en
rf_read_data_valid  input  1  from register file
rf_read_data  input  DATA_WIDTH  from register file
busy  output  1  high whenever state is not IDLE
grant_id  output  1  owner of the current or most recent transaction

Behaviour:
- Reset values: all outputs 0, state IDLE, last_grant = 1 (port 0 wins the first tie), timeout counter 0.
- Reset is asynchronous. Asserting it mid-transaction aborts immediately: no ack is issued and the state returns to IDLE.
- All outputs are registered.
- State machine (IDLE, ISSUE, WAIT_RD, RESP):
  - IDLE: if any req is high, pick the winner.
    - Only one req high: that port wins.
    - Both high: the port that is not last_grant wins.
    - Latch we, addr and wdata from the winner; set grant_id; go to ISSUE.
  - ISSUE, one cycle only:
    - Write: rf_write_en = 1, then go to RESP.
    - Read: rf_read_en = 1, clear the timeout counter, then go to WAIT_RD.
    - rf_address and rf_write_data hold the latched values from ISSUE through RESP.
  - WAIT_RD: both enables are 0.
    - rf_read_data_valid = 1: capture rf_read_data into the owner's rdata, err = 0, go to RESP.
    - Otherwise increment the counter. When the counter reaches TIMEOUT_CYCLES, set the owner's rdata = 0, err = 1, go to RESP.
  - RESP: ack of the owner = 1 for exactly this cycle, err as set, last_grant = grant_id, go to IDLE.
- Latency, with req sampled in IDLE at cycle T:
  - Write: rf_write_en high at T+1, ack at T+2.
  - Read: rf_read_en high at T+1, valid seen at T+2, ack with rdata at T+3.
- A requester must hold req and its command fields until ack. If req is still high in the cycle after ack, that is a new transaction.
- Back-to-back: with both req high continuously, grants alternate 0,1,0,1. Each port is starved for at most one transaction.
- Deassertion of req after the grant is ignored: the transaction completes and acks anyway.
- Invariant: rf_write_en and rf_read_en are never both 1. Each pulses for exactly one cycle per transaction.
- Address is not range-checked; the full AW bits pass through.
- The non-owner's ack, err and rdata are never disturbed.

Test Plan:
- After reset, req0 read of addr 2 → rf_read_en pulse at T+1, ack0 at T+3, rdata0 = 0x01, err0 = 0. Then read addr 3 → rdata0 = 0x08.
- req1 write of 0xA5 to addr 5 → rf_write_en at T+1 with rf_address = 5 and rf_write_data = 0xA5; ack1 at T+2. Then req0 read of addr 5 → rdata0 = 0xA5.
- req0 and req1 both held high for 6 transactions → grant_id sequence 0,1,0,1,0,1; no cycle with both rf enables high; rdata1 unchanged during port 0 acks.
- Stub register file never asserting valid, req1 read → ack1 with err1 = 1 and rdata1 = 0 exactly TIMEOUT_CYCLES + 2 cycles after ISSUE entry (ISSUE → WAIT_RD → RESP); busy drops the next cycle.
- Assert reset_n low during WAIT_RD → all outputs 0 asynchronously; no ack after release; the next tied request is granted to port 0.
- req0 dropped one cycle after grant → transaction still completes and ack0 pulses once; no second transaction starts.
